bus_arbiter_2m: RTL



---
 rtl/bus_arbiter_2m_pkg.sv | 27 ++
 rtl/arb_burst_cnt.sv | 40 ++++
 rtl/bus_arbiter_2m.sv | 110 +++++++++++
 3 files changed

// File: rtl/bus_arbiter_2m_pkg.sv
// bus_arbiter_2m_pkg: state and mux-select encodings shared by the
// two-master arbiter, the bus mux and the slave decoder.
package bus_arbiter_2m_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } arb_state_e;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_e;

   localparam logic [1:0] SEL_M0   = 2'b10;
   localparam logic [1:0] SEL_M1   = 2'b01;
   localparam logic [1:0] SEL_NONE = 2'b00;

   function automatic logic [1:0] sel_of(
      input logic g0,
      input logic g1
   );
      return {g0, g1};
   endfunction

endpackage

// File: rtl/arb_burst_cnt.sv
// arb_burst_cnt: saturating burst counter with synchronous clear;
// limit_o flags the last cycle an owner may keep a contested bus.
module arb_burst_cnt #(
   parameter int MAX_BURST = 8,
   parameter int CNT_W     = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   input  logic inc_i,
   output logic limit_o
);

   localparam bit LIMIT_EN = (MAX_BURST != 0);
   localparam int LIM_INT  = (MAX_BURST > 0) ? MAX_BURST - 1 : 0;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(LIM_INT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && LIMIT_EN && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign limit_o = LIMIT_EN && (cnt_q == LIMIT);

endmodule

// File: rtl/bus_arbiter_2m.sv
// bus_arbiter_2m: registered-grant round-robin arbiter for two masters.
// Define BUS_ARB_PARK_EN to park the idle bus on M0.
module bus_arbiter_2m
   import bus_arbiter_2m_pkg::*;
#(
   parameter int MAX_BURST = 8,
   parameter int CNT_W     = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       m0_req,
   input  logic       m1_req,
   output logic       m0_grant,
   output logic       m1_grant,
   output logic [1:0] sel,
   output logic       busy
);

`ifdef BUS_ARB_PARK_EN
   localparam bit PARK_EN = 1'b1;
`else
   localparam bit PARK_EN = 1'b0;
`endif

   arb_state_e state_q;
   arb_state_e state_d;
   owner_e     last_q;
   owner_e     last_d;
   logic       m0_grant_q;
   logic       m1_grant_q;
   logic       other_req;
   logic       cnt_clr;
   logic       cnt_inc;
   logic       at_limit;

   assign other_req = (state_q == ST_GNT1) ? m0_req : m1_req;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (m0_req && m1_req) begin
               state_d = (last_q == OWN_M1) ? ST_GNT0 : ST_GNT1;
            end else if (m0_req) begin
               state_d = ST_GNT0;
            end else if (m1_req) begin
               state_d = ST_GNT1;
            end
         end
         ST_GNT0: begin
            if (!m0_req) begin
               state_d = m1_req ? ST_GNT1 : ST_IDLE;
            end else if (m1_req && at_limit) begin
               state_d = ST_GNT1;
            end
         end
         ST_GNT1: begin
            if (!m1_req) begin
               state_d = m0_req ? ST_GNT0 : ST_IDLE;
            end else if (m0_req && at_limit) begin
               state_d = ST_GNT0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d != state_q) begin
         if (state_d == ST_GNT0) last_d = OWN_M0;
         if (state_d == ST_GNT1) last_d = OWN_M1;
      end
   end

   // Count only while the bus is contested; any handoff restarts it.
   assign cnt_inc = (state_q != ST_IDLE);
   assign cnt_clr = (state_d != state_q) || !other_req ||
                    (state_q == ST_IDLE);

   arb_burst_cnt #(
      .MAX_BURST (MAX_BURST),
      .CNT_W     (CNT_W)
   ) u_burst_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (cnt_clr),
      .inc_i   (cnt_inc),
      .limit_o (at_limit)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         last_q     <= OWN_M1;
         m0_grant_q <= PARK_EN;
         m1_grant_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         m0_grant_q <= (state_d == ST_GNT0) ||
                       (PARK_EN && (state_d == ST_IDLE));
         m1_grant_q <= (state_d == ST_GNT1);
      end
   end

   assign m0_grant = m0_grant_q;
   assign m1_grant = m1_grant_q;
   assign sel      = sel_of(m0_grant_q, m1_grant_q);
   assign busy     = ((state_q == ST_GNT0) && m0_req) ||
                     ((state_q == ST_GNT1) && m1_req);

endmodule
